// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes per cycle.
// Valid/ready on both sides; a retiring result and a new state may hand off on the same edge.
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCHUNK = 16 / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [127:0]    work_q, work_d;
  logic [3:0]      byte_idx;

  // The S-box is built from the GF(2^8) inverse plus the affine maps rather than
  // from two 256-entry tables, so one inverter per lane serves both directions.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] pre;
    logic [7:0] g;
    pre = inv ? (rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05) : b;
    g   = gf_inv(pre);
    return inv ? g : (g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63);
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    work_d   = work_q;
    in_ready = 1'b0;
    byte_idx = '0;

    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          byte_idx = 4'(int'(cnt_q) * LANES + l);
          work_d[{~byte_idx, 3'b000} +: 8] = sub_byte(work_q[{~byte_idx, 3'b000} +: 8], mode_q);
        end
        if (cnt_q == LAST_CHUNK) state_d = DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the DONE->IDLE retire so back-to-back states see no bubble.
    if (in_valid && in_ready) begin
      state_d = RUN;
      cnt_d   = '0;
      mode_d  = in_inv;
      work_d  = in_state;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      // NOTE: the working register is reset too because it drives out_state, which must read zero after reset.
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = work_q;

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 Parameter LANES, default 4: S-box bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_state/in_inv presented.
REQ-005 in_ready  output  1  block accepts a new state this cycle.
REQ-006 in_inv  input  1  0 = forward SubBytes, 1 = InvSubBytes (FIPS-197 tables).
REQ-007 in_state  input  128  state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-008 out_valid  output  1  out_state holds a completed result.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 out_state  output  128  substituted state, same byte order as in_state.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 FSM states IDLE, RUN, DONE; encoding free.
REQ-013 Input handshake completes on a rising edge with in_valid=1 and in_ready=1; in_state and in_inv SHALL be captured into internal registers, chunk counter cleared to 0, FSM -> RUN.
REQ-014 in_ready = 1 in IDLE; = out_ready in DONE; = 0 in RUN; combinational from state and out_ready only (no dependence on in_valid).
REQ-015 In RUN, each cycle SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register with S(byte) or InvS(byte) per the captured mode; other bytes unchanged.
REQ-016 Counter width ceil(log2(16/LANES)) (minimum 1 bit); when cnt = 16/LANES-1 the final chunk is written and FSM -> DONE; counter never wraps inside a transaction.
REQ-017 Latency: result visible with out_valid=1 exactly 16/LANES cycles after the accepting edge (LANES=16: 1 cycle; LANES=1: 16 cycles).
REQ-018 In DONE, out_valid=1 and out_state SHALL stay stable until the output handshake (out_valid & out_ready on an edge).
REQ-019 out_state = working register; its value in RUN is don't-care to consumers but SHALL never change in IDLE or DONE.
REQ-020 DONE with out_ready=1 and in_valid=0: -> IDLE, out_valid drops next cycle, out_state retains last result.
REQ-021 DONE with out_ready=1 and in_valid=1 (simultaneous): result retired and new state accepted on same edge, -> RUN; no idle bubble.
REQ-022 Changes on in_state/in_inv after acceptance SHALL NOT affect the in-flight transaction.
REQ-023 S-box implemented as LANES forward and LANES inverse lookups (or equivalent shared logic) bit-exact to FIPS-197, mode selected per transaction.

Reset
REQ-024 With rst=1 on an edge: FSM -> IDLE, counter = 0, out_valid = 0, busy = 0, out_state = 128'h0, captured mode = 0.
REQ-025 Reset in RUN or DONE SHALL abort the transaction; no out_valid pulse for it; in_ready = 1 on first cycle after rst deasserts.
REQ-026 rst has priority over every handshake on the same edge.

Verification
REQ-027 LANES=4, forward, in_state=128'h00112233445566778899aabbccddeeff, out_ready=1 -> out_valid 4 cycles after accept, out_state=128'h638293c31bfc33f5c4eeacea4bc12816.
REQ-028 Inverse, in_state=128'h638293c31bfc33f5c4eeacea4bc12816 -> out_state=128'h00112233445566778899aabbccddeeff; all-zero input inverse -> 16 bytes 8'h52; forward -> 16 bytes 8'h63.
REQ-029 Repeat REQ-027 for LANES=1, 2, 8, 16 -> identical out_state, latency 16, 8, 2, 1 cycles respectively.
REQ-030 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, out_state stable; raise out_ready -> retire plus new accept on same edge, next result after 16/LANES cycles.
REQ-031 Assert rst for one cycle mid-RUN (cnt=2, LANES=4) -> out_valid never asserts for that input, out_state=0, busy=0, next transaction produces correct result.
REQ-032 Alternate forward/inverse transactions back-to-back with in_inv toggled after each accept -> each result uses mode captured at its own accept.
